// File: rtl/jtcps1_sdram_ctrl.sv
// SDR SDRAM controller for the CPS1 four-bank request interface (x16, BL2, CL2, auto-precharge).
// Define JTCPS1_SDRAM_RR_EN for round-robin bank arbitration; otherwise fixed priority ba0 > ba3 > ba1 > ba2.
module jtcps1_sdram_ctrl #(
    parameter int INIT_WAIT   = 9600,
    parameter int REFRESH_INT = 64,
    parameter int TRFC        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] ba0_addr,
    input  logic        ba0_rd,
    input  logic        ba0_wr,
    input  logic [15:0] ba0_din,
    input  logic [1:0]  ba0_din_m,
    output logic        ba0_ack,
    output logic        ba0_rdy,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic        ba1_rd,
    input  logic        ba2_rd,
    input  logic        ba3_rd,
    output logic        ba1_ack,
    output logic        ba2_ack,
    output logic        ba3_ack,
    output logic        ba1_rdy,
    output logic        ba2_rdy,
    output logic        ba3_rdy,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    input  logic [1:0]  prog_ba,
    input  logic        prog_we,
    output logic        prog_rdy,
    input  logic        refresh_en,
    output logic [31:0] data_read,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_a,
    output logic [1:0]  sdram_ba,
    output logic [1:0]  sdram_dqm,
    input  logic [15:0] sdram_dq_in,
    output logic [15:0] sdram_dq_out,
    output logic        sdram_dq_oe
);
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_REF  = 4'b0001;
    localparam logic [3:0] CMD_MODE = 4'b0000;

    // Init schedule, in cycles counted from reset release
    localparam logic [15:0] T_PRE  = 16'(INIT_WAIT);
    localparam logic [15:0] T_REF1 = 16'(INIT_WAIT + 3);
    localparam logic [15:0] T_REF2 = 16'(INIT_WAIT + 3 + TRFC);
    localparam logic [15:0] T_MODE = 16'(INIT_WAIT + 3 + 2 * TRFC);
    localparam logic [15:0] T_DONE = 16'(INIT_WAIT + 5 + 2 * TRFC);

    localparam int              RW       = $clog2(REFRESH_INT + 1);
    localparam logic [RW-1:0]   RMAX     = RW'(REFRESH_INT);
    localparam logic [4:0]      RFSH_END = 5'(TRFC - 2);

    typedef enum logic [2:0] {INIT, IDLE, ACT, RD, WR, RFSH} state_t;

    state_t        state;
    logic [15:0]   init_cnt;
    logic [4:0]    cnt;
    logic [RW-1:0] rcnt;
    logic [3:0]    ack;
    logic [3:0]    rdy;
    logic [1:0]    cur_bank;
    logic          cur_prog;
    logic          cur_wr;
    logic [8:0]    cur_col;
    logic [15:0]   cur_din;
    logic [1:0]    cur_mask;
    logic [15:0]   rd_lo;
`ifdef JTCPS1_SDRAM_RR_EN
    logic [1:0]    last_bank;
`endif

    logic [3:0]  req;
    logic        pick_vld;
    logic [1:0]  pick;
    logic [21:0] pick_addr;

    assign req = {ba3_rd, ba2_rd, ba1_rd, ba0_rd | ba0_wr};
    assign {ba3_ack, ba2_ack, ba1_ack, ba0_ack} = ack;
    assign {ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy} = rdy;

    // Later assignments override earlier ones, so the last match is the winner
    always_comb begin
        pick_vld = |req;
        pick     = 2'd0;
`ifdef JTCPS1_SDRAM_RR_EN
        for (int i = 4; i >= 1; i--) begin
            if (req[last_bank + 2'(i)]) pick = last_bank + 2'(i);
        end
`else
        if (req[2]) pick = 2'd2;
        if (req[1]) pick = 2'd1;
        if (req[3]) pick = 2'd3;
        if (req[0]) pick = 2'd0;
`endif
    end

    always_comb begin
        case (pick)
            2'd0:    pick_addr = ba0_addr;
            2'd1:    pick_addr = ba1_addr;
            2'd2:    pick_addr = ba2_addr;
            default: pick_addr = ba3_addr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= INIT;
            init_cnt     <= '0;
            cnt          <= '0;
            rcnt         <= '0;
            ack          <= '0;
            rdy          <= '0;
            prog_rdy     <= 1'b0;
            cur_bank     <= '0;
            cur_prog     <= 1'b0;
            cur_wr       <= 1'b0;
            cur_col      <= '0;
            cur_din      <= '0;
            cur_mask     <= 2'b11;
            rd_lo        <= '0;
`ifdef JTCPS1_SDRAM_RR_EN
            last_bank    <= '0;
`endif
            data_read    <= '0;
            sdram_cmd    <= CMD_NOP;
            sdram_a      <= '0;
            sdram_ba     <= '0;
            sdram_dqm    <= 2'b11;
            sdram_dq_out <= '0;
            sdram_dq_oe  <= 1'b0;
        end else begin
            sdram_cmd <= CMD_NOP;
            ack       <= '0;
            rdy       <= '0;
            prog_rdy  <= 1'b0;
            cnt       <= cnt + 5'd1;
            if (rcnt != RMAX) rcnt <= rcnt + RW'(1);

            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 16'd1;
                    if (init_cnt == T_PRE) begin
                        sdram_cmd <= CMD_PRE;
                        sdram_a   <= 13'h0400;
                    end
                    if (init_cnt == T_REF1 || init_cnt == T_REF2) begin
                        sdram_cmd <= CMD_REF;
                        rcnt      <= '0;
                    end
                    if (init_cnt == T_MODE) begin
                        sdram_cmd <= CMD_MODE;
                        sdram_a   <= 13'h0021;
                    end
                    if (init_cnt == T_DONE) state <= IDLE;
                end
                // The cycle that issues ACTIVE/REFRESH is cycle 0 of cnt
                IDLE: begin
                    cnt <= 5'd0;
                    if (prog_we) begin
                        state     <= ACT;
                        sdram_cmd <= CMD_ACT;
                        sdram_ba  <= prog_ba;
                        sdram_a   <= prog_addr[21:9];
                        cur_prog  <= 1'b1;
                        cur_wr    <= 1'b1;
                        cur_col   <= prog_addr[8:0];
                        cur_din   <= prog_data;
                        cur_mask  <= prog_mask;
                    end else if (refresh_en && rcnt == RMAX) begin
                        state     <= RFSH;
                        sdram_cmd <= CMD_REF;
                        rcnt      <= '0;
                    end else if (pick_vld) begin
                        state     <= ACT;
                        sdram_cmd <= CMD_ACT;
                        sdram_ba  <= pick;
                        sdram_a   <= pick_addr[21:9];
                        ack[pick] <= 1'b1;
                        cur_bank  <= pick;
                        cur_prog  <= 1'b0;
                        cur_wr    <= (pick == 2'd0) && ba0_wr;
                        cur_col   <= pick_addr[8:0];
                        cur_din   <= ba0_din;
                        cur_mask  <= ba0_din_m;
`ifdef JTCPS1_SDRAM_RR_EN
                        last_bank <= pick;
`endif
                    end
                end
                ACT: begin
                    if (cnt == 5'd1) begin
                        sdram_a <= {2'b00, 1'b1, 1'b0, cur_col};
                        if (cur_wr) begin
                            state        <= WR;
                            sdram_cmd    <= CMD_WR;
                            sdram_dq_oe  <= 1'b1;
                            sdram_dq_out <= cur_din;
                            sdram_dqm    <= cur_mask;
                        end else begin
                            state     <= RD;
                            sdram_cmd <= CMD_RD;
                            sdram_dqm <= 2'b00;
                        end
                    end
                end
                RD: begin
                    if (cnt == 5'd5) rd_lo <= sdram_dq_in;
                    if (cnt == 5'd6) begin
                        data_read     <= {sdram_dq_in, rd_lo};
                        rdy[cur_bank] <= 1'b1;
                        sdram_dqm     <= 2'b11;
                        state         <= IDLE;
                    end
                end
                WR: begin
                    if (cnt == 5'd2) begin
                        sdram_dqm   <= 2'b11;
                        sdram_dq_oe <= 1'b0;
                    end
                    if (cnt == 5'd5) begin
                        if (cur_prog) prog_rdy <= 1'b1;
                        else rdy[cur_bank] <= 1'b1;
                        state <= IDLE;
                    end
                end
                RFSH: begin
                    if (cnt == RFSH_END) state <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_jtcps1_sdram_ctrl.sv
// Directed bench for jtcps1_sdram_ctrl: init sequence, read/write timing, arbitration, refresh, download, reset.
module tb_jtcps1_sdram_ctrl;
    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_ACT  = 4'b0011;
    localparam logic [3:0] C_RD   = 4'b0101;
    localparam logic [3:0] C_WR   = 4'b0100;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MODE = 4'b0000;

    logic        clk, rst;
    logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr, prog_addr;
    logic        ba0_rd, ba0_wr, ba1_rd, ba2_rd, ba3_rd, prog_we, refresh_en;
    logic [15:0] ba0_din, prog_data, sdram_dq_in;
    logic [1:0]  ba0_din_m, prog_mask, prog_ba;
    logic        ba0_ack, ba1_ack, ba2_ack, ba3_ack;
    logic        ba0_rdy, ba1_rdy, ba2_rdy, ba3_rdy, prog_rdy;
    logic [31:0] data_read;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_a;
    logic [1:0]  sdram_ba, sdram_dqm;
    logic [15:0] sdram_dq_out;
    logic        sdram_dq_oe;

    wire [3:0] acks = {ba3_ack, ba2_ack, ba1_ack, ba0_ack};
    wire [4:0] rdys = {prog_rdy, ba3_rdy, ba2_rdy, ba1_rdy, ba0_rdy};

    int checks = 0;
    int errors = 0;
    logic [15:0] model_w0 = 16'h0000;
    logic [15:0] model_w1 = 16'h0000;

    jtcps1_sdram_ctrl #(.INIT_WAIT(16), .REFRESH_INT(64), .TRFC(8)) dut (
        .clk(clk), .rst(rst),
        .ba0_addr(ba0_addr), .ba0_rd(ba0_rd), .ba0_wr(ba0_wr), .ba0_din(ba0_din),
        .ba0_din_m(ba0_din_m), .ba0_ack(ba0_ack), .ba0_rdy(ba0_rdy),
        .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
        .ba1_rd(ba1_rd), .ba2_rd(ba2_rd), .ba3_rd(ba3_rd),
        .ba1_ack(ba1_ack), .ba2_ack(ba2_ack), .ba3_ack(ba3_ack),
        .ba1_rdy(ba1_rdy), .ba2_rdy(ba2_rdy), .ba3_rdy(ba3_rdy),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_ba(prog_ba), .prog_we(prog_we), .prog_rdy(prog_rdy),
        .refresh_en(refresh_en), .data_read(data_read),
        .sdram_cmd(sdram_cmd), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
        .sdram_dqm(sdram_dqm), .sdram_dq_in(sdram_dq_in),
        .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: words appear on DQ 3 and 4 cycles after the READ command cycle
    initial begin
        int age;
        age = -1;
        sdram_dq_in = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (sdram_cmd == C_RD) age = 0;
            else if (age >= 0 && age < 100) age++;
            sdram_dq_in = (age == 3) ? model_w0 : (age == 4) ? model_w1 : 16'h0000;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0]  tr [0:37];
        logic [12:0] ta [0:37];
        int nops, mid, acked;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (sdram_cmd !== C_NOP) begin errors++; $display("FAIL rst_cmd: got %b expected %b", sdram_cmd, C_NOP); end
        checks++; if (sdram_a !== 13'h0) begin errors++; $display("FAIL rst_a: got %h expected 0", sdram_a); end
        checks++; if (sdram_ba !== 2'b00) begin errors++; $display("FAIL rst_ba: got %b expected 00", sdram_ba); end
        checks++; if (sdram_dqm !== 2'b11) begin errors++; $display("FAIL rst_dqm: got %b expected 11", sdram_dqm); end
        checks++; if (sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_oe: got %b expected 0", sdram_dq_oe); end
        checks++; if (data_read !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 0", data_read); end
        checks++; if (acks !== 4'h0 || rdys !== 5'h0) begin errors++; $display("FAIL rst_ackrdy: got %b/%b expected 0/0", acks, rdys); end
        @(negedge clk);
        rst = 1'b0;
        ba1_addr = 22'h12345;
        ba1_rd = 1'b1;
        acked = 0;
        for (int i = 0; i < 38; i++) begin
            step();
            tr[i] = sdram_cmd;
            ta[i] = sdram_a;
            if (acks != 4'h0) acked++;
        end
        nops = 0;
        for (int i = 0; i < 16; i++) if (tr[i] == C_NOP) nops++;
        checks++; if (nops != 16) begin errors++; $display("FAIL init_wait: got %0d NOPs expected 16", nops); end
        checks++; if (tr[16] !== C_PRE || ta[16][10] !== 1'b1) begin errors++; $display("FAIL init_pre: got %b a=%h expected %b with A10", tr[16], ta[16], C_PRE); end
        checks++; if (tr[17] !== C_NOP || tr[18] !== C_NOP) begin errors++; $display("FAIL init_pre_gap: got %b %b expected NOP NOP", tr[17], tr[18]); end
        checks++; if (tr[19] !== C_REF) begin errors++; $display("FAIL init_ref1: got %b expected %b", tr[19], C_REF); end
        mid = 0;
        for (int i = 20; i < 27; i++) if (tr[i] != C_NOP) mid++;
        checks++; if (mid != 0) begin errors++; $display("FAIL init_trfc: got %0d commands inside TRFC expected 0", mid); end
        checks++; if (tr[27] !== C_REF) begin errors++; $display("FAIL init_ref2: got %b expected %b", tr[27], C_REF); end
        checks++; if (tr[35] !== C_MODE || ta[35] !== 13'h0021) begin errors++; $display("FAIL init_mode: got %b a=%h expected %b a=0021", tr[35], ta[35], C_MODE); end
        checks++; if (acked != 0) begin errors++; $display("FAIL init_noack: got %0d acks expected 0", acked); end
    endtask

    task automatic test_read();
        model_w0 = 16'hAAAA;
        model_w1 = 16'h5555;
        step();
        checks++; if (sdram_cmd !== C_ACT || ba1_ack !== 1'b1) begin errors++; $display("FAIL read_act: got cmd %b ack %b expected %b 1", sdram_cmd, ba1_ack, C_ACT); end
        checks++; if (sdram_ba !== 2'd1 || sdram_a !== 13'h091) begin errors++; $display("FAIL read_row: got ba %0d a %h expected 1 091", sdram_ba, sdram_a); end
        ba1_rd = 1'b0;
        step(); step();
        checks++; if (sdram_cmd !== C_RD) begin errors++; $display("FAIL read_cmd: got %b expected %b", sdram_cmd, C_RD); end
        checks++; if (sdram_a !== 13'h545 || sdram_dqm !== 2'b00) begin errors++; $display("FAIL read_col: got a %h dqm %b expected 545 00", sdram_a, sdram_dqm); end
        repeat (4) step();
        checks++; if (ba1_rdy !== 1'b0) begin errors++; $display("FAIL read_rdy_early: got %b expected 0", ba1_rdy); end
        step();
        checks++; if (ba1_rdy !== 1'b1) begin errors++; $display("FAIL read_rdy: got %b expected 1", ba1_rdy); end
        checks++; if (data_read !== 32'h5555AAAA) begin errors++; $display("FAIL read_data: got %h expected 5555AAAA", data_read); end
        step();
        checks++; if (ba1_rdy !== 1'b0 || data_read !== 32'h5555AAAA) begin errors++; $display("FAIL read_hold: got rdy %b data %h expected 0 5555AAAA", ba1_rdy, data_read); end
    endtask

    task automatic test_write();
        int k;
        ba0_addr = 22'h00C07;
        ba0_din = 16'hBEEF;
        ba0_din_m = 2'b01;
        ba0_wr = 1'b1;
        k = 0;
        do begin step(); k++; end while (sdram_cmd !== C_ACT && k < 30);
        checks++; if (sdram_cmd !== C_ACT || ba0_ack !== 1'b1 || sdram_a !== 13'h006) begin errors++; $display("FAIL write_act: got cmd %b ack %b a %h expected %b 1 006", sdram_cmd, ba0_ack, sdram_a, C_ACT); end
        ba0_wr = 1'b0;
        ba0_din = 16'h0000;
        ba0_din_m = 2'b11;
        step(); step();
        checks++; if (sdram_cmd !== C_WR || sdram_a !== 13'h407) begin errors++; $display("FAIL write_cmd: got %b a %h expected %b 407", sdram_cmd, sdram_a, C_WR); end
        checks++; if (sdram_dq_out !== 16'hBEEF || sdram_dq_oe !== 1'b1 || sdram_dqm !== 2'b01) begin errors++; $display("FAIL write_dq: got %h oe %b dqm %b expected BEEF 1 01", sdram_dq_out, sdram_dq_oe, sdram_dqm); end
        step();
        checks++; if (sdram_dqm !== 2'b11 || sdram_dq_oe !== 1'b0) begin errors++; $display("FAIL write_mask2: got dqm %b oe %b expected 11 0", sdram_dqm, sdram_dq_oe); end
        step(); step();
        checks++; if (ba0_rdy !== 1'b0) begin errors++; $display("FAIL write_rdy_early: got %b expected 0", ba0_rdy); end
        step();
        checks++; if (ba0_rdy !== 1'b1 || data_read !== 32'h5555AAAA) begin errors++; $display("FAIL write_rdy: got rdy %b data %h expected 1 5555AAAA", ba0_rdy, data_read); end
        step();
    endtask

    task automatic test_order();
        int exp_order [3];
        int k, served;
`ifdef JTCPS1_SDRAM_RR_EN
        exp_order = '{1, 2, 3};
`else
        exp_order = '{3, 1, 2};
`endif
        ba1_addr = 22'h00201;
        ba2_addr = 22'h00402;
        ba3_addr = 22'h00603;
        ba1_rd = 1'b1; ba2_rd = 1'b1; ba3_rd = 1'b1;
        for (int s = 0; s < 3; s++) begin
            k = 0;
            do begin step(); k++; end while (sdram_cmd !== C_ACT && k < 30);
            served = ba1_ack ? 1 : ba2_ack ? 2 : ba3_ack ? 3 : ba0_ack ? 0 : -1;
            checks++; if (served != exp_order[s]) begin errors++; $display("FAIL order_%0d: got bank %0d expected %0d", s, served, exp_order[s]); end
            if (served == 1) ba1_rd = 1'b0;
            if (served == 2) ba2_rd = 1'b0;
            if (served == 3) ba3_rd = 1'b0;
        end
        ba1_rd = 1'b0; ba2_rd = 1'b0; ba3_rd = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_refresh();
        int k, busy;
        ba2_addr = 22'h00402;
        refresh_en = 1'b1;
        ba2_rd = 1'b1;
        k = 0;
        do begin step(); k++; end while (sdram_cmd !== C_REF && k < 90);
        checks++; if (sdram_cmd !== C_REF) begin errors++; $display("FAIL refresh_issue: got %b after %0d cycles expected %b", sdram_cmd, k, C_REF); end
        refresh_en = 1'b0;
        busy = 0;
        for (int i = 1; i < 8; i++) begin
            step();
            if (sdram_cmd != C_NOP) busy++;
        end
        checks++; if (busy != 0) begin errors++; $display("FAIL refresh_trfc: got %0d commands inside TRFC expected 0", busy); end
        step();
        checks++; if (sdram_cmd !== C_ACT || ba2_ack !== 1'b1) begin errors++; $display("FAIL refresh_then_ack: got cmd %b ack %b expected %b 1", sdram_cmd, ba2_ack, C_ACT); end
        ba2_rd = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_prog();
        model_w0 = 16'h1111;
        model_w1 = 16'h2222;
        prog_addr = 22'h005FF;
        prog_ba = 2'd2;
        prog_data = 16'h1234;
        prog_mask = 2'b10;
        prog_we = 1'b1;
        ba0_addr = 22'h00A03;
        ba0_rd = 1'b1;
        step();
        checks++; if (sdram_cmd !== C_ACT || ba0_ack !== 1'b0 || sdram_ba !== 2'd2 || sdram_a !== 13'h002) begin errors++; $display("FAIL prog_first: got cmd %b ack0 %b ba %0d a %h expected %b 0 2 002", sdram_cmd, ba0_ack, sdram_ba, sdram_a, C_ACT); end
        prog_we = 1'b0;
        step(); step();
        checks++; if (sdram_cmd !== C_WR || sdram_a !== 13'h5FF) begin errors++; $display("FAIL prog_cmd: got %b a %h expected %b 5FF", sdram_cmd, sdram_a, C_WR); end
        checks++; if (sdram_dq_out !== 16'h1234 || sdram_dqm !== 2'b10) begin errors++; $display("FAIL prog_dq: got %h dqm %b expected 1234 10", sdram_dq_out, sdram_dqm); end
        repeat (4) step();
        checks++; if (prog_rdy !== 1'b1 || ba0_rdy !== 1'b0) begin errors++; $display("FAIL prog_rdy: got prog %b ba0 %b expected 1 0", prog_rdy, ba0_rdy); end
        step();
        checks++; if (sdram_cmd !== C_ACT || ba0_ack !== 1'b1 || sdram_a !== 13'h005) begin errors++; $display("FAIL prog_then_ba0: got cmd %b ack %b a %h expected %b 1 005", sdram_cmd, ba0_ack, sdram_a, C_ACT); end
        ba0_rd = 1'b0;
        repeat (7) step();
        checks++; if (ba0_rdy !== 1'b1 || data_read !== 32'h22221111) begin errors++; $display("FAIL ba0_read: got rdy %b data %h expected 1 22221111", ba0_rdy, data_read); end
    endtask

    task automatic test_reset_mid();
        int k, nops;
        ba3_addr = 22'h3FFFFF;
        ba3_rd = 1'b1;
        k = 0;
        do begin step(); k++; end while (sdram_cmd !== C_ACT && k < 30);
        ba3_rd = 1'b0;
        step(); step();
        checks++; if (sdram_cmd !== C_RD || sdram_dqm !== 2'b00) begin errors++; $display("FAIL mid_read: got %b dqm %b expected %b 00", sdram_cmd, sdram_dqm, C_RD); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (sdram_cmd !== C_NOP || sdram_a !== 13'h0 || sdram_dqm !== 2'b11) begin errors++; $display("FAIL mid_rst_pins: got %b a %h dqm %b expected %b 0 11", sdram_cmd, sdram_a, sdram_dqm, C_NOP); end
        checks++; if (data_read !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", data_read); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        nops = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (sdram_cmd == C_NOP) nops++;
        end
        checks++; if (nops != 16) begin errors++; $display("FAIL reinit_wait: got %0d NOPs expected 16", nops); end
        step();
        checks++; if (sdram_cmd !== C_PRE || sdram_a[10] !== 1'b1) begin errors++; $display("FAIL reinit_pre: got %b a %h expected %b with A10", sdram_cmd, sdram_a, C_PRE); end
    endtask

    initial begin
        rst = 1'b1;
        ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0; prog_addr = '0;
        ba0_rd = 1'b0; ba0_wr = 1'b0; ba1_rd = 1'b0; ba2_rd = 1'b0; ba3_rd = 1'b0;
        ba0_din = '0; ba0_din_m = 2'b11;
        prog_we = 1'b0; prog_data = '0; prog_mask = 2'b11; prog_ba = '0;
        refresh_en = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_order();
        test_refresh();
        test_prog();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
